// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory loader.
// Frames begin with MAGIC; DEPTH bounds the word count a frame may carry.
package imem_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word.
// o_ready strobes in the same cycle as the 4th byte; o_word is valid with it.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_ready
);

  logic [1:0] idx_reg;
  logic [7:0] lane_reg [0:2];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      idx_reg <= 2'd0;
    end else if (i_valid) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  // Lanes 0..2 are held; lane 3 comes straight from the incoming byte.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      localparam logic [1:0] LANE_IDX = 2'(gi);
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          lane_reg[gi] <= 8'd0;
        end else if (i_valid && idx_reg == LANE_IDX) begin
          lane_reg[gi] <= i_byte;
        end
      end
    end
  endgenerate

  assign o_word  = {i_byte, lane_reg[2], lane_reg[1], lane_reg[0]};
  assign o_ready = i_valid && (idx_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Frame-driven instruction-memory writer; keeps the CPU held until a frame
// (MAGIC, 16-bit word count, data, checksum) has loaded cleanly.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned WORD_W = imem_loader_pkg::WORD_W,
  parameter int unsigned DEPTH  = imem_loader_pkg::DEPTH,
  parameter int unsigned ADDR_W = imem_loader_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rxData,
  input  logic              i_rxValid,
  output logic              o_rxReady,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [WORD_W-1:0] o_wdata,
  input  logic              i_memBusy,
  output logic              o_cpuHold,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t      state_reg;
  logic [7:0]  cnt_lo_reg;
  logic [15:0] words_left_reg;
  logic [7:0]  sum_reg;

  logic        rx_fire;
  logic [15:0] count_next;
  logic        frame_start;
  logic        pk_valid;
  logic        pk_ready;
  logic [31:0] pk_word;

  assign rx_fire     = i_rxValid && o_rxReady;
  assign count_next  = {i_rxData, cnt_lo_reg};
  assign frame_start = rx_fire && (i_rxData == MAGIC) &&
                       (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR);
  assign pk_valid    = rx_fire && (state_reg == S_DATA);

  word_packer u_packer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (frame_start),
    .i_valid (pk_valid),
    .i_byte  (i_rxData),
    .o_word  (pk_word),
    .o_ready (pk_ready)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= S_IDLE;
      o_rxReady      <= 1'b1;
      o_wen          <= 1'b0;
      o_waddr        <= '0;
      o_wdata        <= '0;
      o_cpuHold      <= 1'b1;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      cnt_lo_reg     <= 8'd0;
      words_left_reg <= 16'd0;
      sum_reg        <= 8'd0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (frame_start) begin
            state_reg <= S_LEN0;
            o_cpuHold <= 1'b1;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_waddr   <= '0;
            sum_reg   <= 8'd0;
          end
        end
        S_LEN0: begin
          if (rx_fire) begin
            cnt_lo_reg <= i_rxData;
            state_reg  <= S_LEN1;
          end
        end
        S_LEN1: begin
          // Length is checked at full 16-bit width so the address never wraps.
          if (rx_fire) begin
            if (count_next == 16'd0) begin
              state_reg <= S_CSUM;
            end else if (count_next > DEPTH16) begin
              state_reg <= S_ERR;
              o_err     <= 1'b1;
            end else begin
              words_left_reg <= count_next;
              state_reg      <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            sum_reg <= sum_reg + i_rxData;
            if (pk_ready) begin
              o_wen     <= 1'b1;
              o_wdata   <= WORD_W'(pk_word);
              o_rxReady <= 1'b0;
              state_reg <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (!i_memBusy) begin
            o_wen          <= 1'b0;
            o_rxReady      <= 1'b1;
            o_waddr        <= o_waddr + 1'b1;
            words_left_reg <= words_left_reg - 16'd1;
            state_reg      <= (words_left_reg == 16'd1) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: begin
          if (rx_fire) begin
            if (i_rxData == sum_reg) begin
              state_reg <= S_DONE;
              o_done    <= 1'b1;
              o_cpuHold <= 1'b0;
            end else begin
              state_reg <= S_ERR;
              o_err     <= 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are pushed byte by byte and every
// completed memory write is logged by a monitor for the tests to inspect.
module tb_imem_loader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_rxData = 8'd0;
  logic        i_rxValid = 1'b0;
  logic        o_rxReady;
  logic        o_wen;
  logic [9:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        i_memBusy = 1'b0;
  logic        o_cpuHold;
  logic        o_done;
  logic        o_err;

  int n_cmp = 0;
  int n_bad = 0;

  int          wr_cnt = 0;
  int          wen_cycles = 0;
  logic [9:0]  wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  logic [7:0]  tx_q [$];

  imem_loader dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rxData  (i_rxData),
    .i_rxValid (i_rxValid),
    .o_rxReady (o_rxReady),
    .o_wen     (o_wen),
    .o_waddr   (o_waddr),
    .o_wdata   (o_wdata),
    .i_memBusy (i_memBusy),
    .o_cpuHold (o_cpuHold),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  // A write completes on the coming posedge when o_wen & !i_memBusy here.
  always @(negedge i_clk) begin
    if (!i_rst && o_wen) begin
      wen_cycles = wen_cycles + 1;
      if (!i_memBusy) begin
        if (wr_cnt < 64) begin
          wr_addr[wr_cnt] = o_waddr;
          wr_data[wr_cnt] = o_wdata;
        end
        wr_cnt = wr_cnt + 1;
        $display("write  addr=%0d data=%08h", o_waddr, o_wdata);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    i_rxData  = b;
    i_rxValid = 1'b1;
    n = 0;
    while (!o_rxReady && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_rxReady) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_timeout: o_rxReady stayed %b, required 1", o_rxReady);
    end
    @(negedge i_clk);
    i_rxValid = 1'b0;
    $display("byte   %02h accepted", b);
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_rxReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_rxReady); end
    n_cmp++; if (o_wen !== 1'b0) begin n_bad++; $display("FAIL reset_wen: got %b want 0", o_wen); end
    n_cmp++; if (o_waddr !== 10'd0) begin n_bad++; $display("FAIL reset_waddr: got %0d want 0", o_waddr); end
    n_cmp++; if (o_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", o_wdata); end
    n_cmp++; if (o_cpuHold !== 1'b1) begin n_bad++; $display("FAIL reset_hold: got %b want 1", o_cpuHold); end
    n_cmp++; if ({o_done, o_err} !== 2'b00) begin n_bad++; $display("FAIL reset_done_err: got %b want 00", {o_done, o_err}); end
  endtask

  // Checksum of data bytes 13,00,00,00,93,00,10,00 is 0xB6.
  task automatic test_good_frame();
    int base;
    base = wr_cnt;
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_q();
    n_cmp++; if (wr_cnt - base !== 2) begin n_bad++; $display("FAIL good_nwrites: got %0d want 2", wr_cnt - base); end
    if (wr_cnt - base == 2) begin
      n_cmp++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h00000013) begin n_bad++; $display("FAIL good_w0: got [%0d]=%h want [0]=00000013", wr_addr[base], wr_data[base]); end
      n_cmp++; if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'h00100093) begin n_bad++; $display("FAIL good_w1: got [%0d]=%h want [1]=00100093", wr_addr[base+1], wr_data[base+1]); end
    end
    n_cmp++; if ({o_done, o_cpuHold, o_err} !== 3'b100) begin n_bad++; $display("FAIL good_status: got done/hold/err=%b want 100", {o_done, o_cpuHold, o_err}); end
  endtask

  // Starts from DONE, so the MAGIC also exercises the restart path.
  task automatic test_bad_csum();
    int base;
    base = wr_cnt;
    send_byte(8'hA5);
    n_cmp++; if ({o_cpuHold, o_done, o_waddr} !== {1'b1, 1'b0, 10'd0}) begin n_bad++; $display("FAIL restart: got hold=%b done=%b addr=%0d want 1 0 0", o_cpuHold, o_done, o_waddr); end
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    send_q();
    n_cmp++; if (wr_cnt - base !== 2) begin n_bad++; $display("FAIL badcs_nwrites: got %0d want 2", wr_cnt - base); end
    n_cmp++; if ({o_err, o_cpuHold, o_done} !== 3'b110) begin n_bad++; $display("FAIL badcs_status: got err/hold/done=%b want 110", {o_err, o_cpuHold, o_done}); end
  endtask

  task automatic test_overlength();
    int base_w;
    do_reset();
    base_w = wen_cycles;
    tx_q = '{8'hA5, 8'h01, 8'h04};
    send_q();
    n_cmp++; if ({o_err, o_cpuHold} !== 2'b11) begin n_bad++; $display("FAIL overlen_err: got err/hold=%b want 11", {o_err, o_cpuHold}); end
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_q();
    n_cmp++; if (wen_cycles - base_w !== 0) begin n_bad++; $display("FAIL overlen_wen: got %0d wen cycles want 0", wen_cycles - base_w); end
  endtask

  // Checksum DE+AD+BE+EF mod 256 = 0x38.
  task automatic test_mem_busy();
    int base, base_w;
    logic [9:0]  a0;
    logic [31:0] d0;
    do_reset();
    base = wr_cnt;
    base_w = wen_cycles;
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE};
    send_q();
    i_memBusy = 1'b1;
    send_byte(8'hEF);
    a0 = o_waddr;
    d0 = o_wdata;
    n_cmp++; if ({o_wen, o_rxReady} !== 2'b10 || d0 !== 32'hEFBEADDE || a0 !== 10'd0) begin n_bad++; $display("FAIL busy_first: got wen=%b rdy=%b [%0d]=%h want 1 0 [0]=efbeadde", o_wen, o_rxReady, a0, d0); end
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      n_cmp++; if ({o_wen, o_rxReady} !== 2'b10 || o_waddr !== a0 || o_wdata !== d0) begin n_bad++; $display("FAIL busy_hold%0d: got wen=%b rdy=%b [%0d]=%h", k, o_wen, o_rxReady, o_waddr, o_wdata); end
    end
    i_memBusy = 1'b0;
    send_byte(8'h38);
    n_cmp++; if (wen_cycles - base_w !== 4) begin n_bad++; $display("FAIL busy_wen_cycles: got %0d want 4", wen_cycles - base_w); end
    n_cmp++; if (wr_cnt - base !== 1) begin n_bad++; $display("FAIL busy_nwrites: got %0d want 1", wr_cnt - base); end
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL busy_done: got %b want 1", o_done); end
  endtask

  task automatic test_garbage_empty();
    int base;
    do_reset();
    base = wr_cnt;
    tx_q = '{8'h00, 8'hFF, 8'h12};
    send_q();
    n_cmp++; if ({o_cpuHold, o_done, o_err} !== 3'b100) begin n_bad++; $display("FAIL garbage_idle: got hold/done/err=%b want 100", {o_cpuHold, o_done, o_err}); end
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    n_cmp++; if ({o_done, o_cpuHold, o_err} !== 3'b100) begin n_bad++; $display("FAIL empty_done: got done/hold/err=%b want 100", {o_done, o_cpuHold, o_err}); end
    n_cmp++; if (wr_cnt - base !== 0) begin n_bad++; $display("FAIL empty_nwrites: got %0d want 0", wr_cnt - base); end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    base = wr_cnt;
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_q();
    do_reset();
    n_cmp++; if ({o_rxReady, o_wen, o_cpuHold, o_done, o_err} !== 5'b10100 || o_waddr !== 10'd0) begin n_bad++; $display("FAIL midrst_outputs: got rdy/wen/hold/done/err=%b addr=%0d want 10100 0", {o_rxReady, o_wen, o_cpuHold, o_done, o_err}, o_waddr); end
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_q();
    n_cmp++; if (wr_cnt - base !== 2) begin n_bad++; $display("FAIL midrst_nwrites: got %0d want 2", wr_cnt - base); end
    if (wr_cnt - base == 2) begin
      n_cmp++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h00000013) begin n_bad++; $display("FAIL midrst_w0: got [%0d]=%h want [0]=00000013", wr_addr[base], wr_data[base]); end
    end
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL midrst_done: got %b want 1", o_done); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_overlength();
    test_mem_busy();
    test_garbage_empty();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
